moore_seq_counter: RTL and testbench
====================================

# moore_seq_counter

Parametrised Moore state machine that counts asserted cycles of a serial input and raises a level output while in its terminal state. It generalises the fixed four-state ones-counter used in the finite-state-machine library: the terminal count, counter width, zero-handling mode and terminal behaviour are all configurable. It adds enable, synchronous clear, a state readout and an entry pulse. It sits between a serial bit source and downstream control logic as a programmable event/threshold detector.

## Interface
- WIDTH, 4: state register width in bits; states 0 .. 2^WIDTH-1 are addressable.
- TARGET, 3: terminal state index. Legal range 1 .. 2^WIDTH-1; any other value is an elaboration-time error.
- MODE, 0: 0 = cumulative, where in=0 holds the state; 1 = consecutive, where in=0 below TARGET returns to state 0.
- WRAP, 1: 1 = in=1 in the terminal state returns to state 0; 0 = the terminal state is held until clr or rst.

Ports:
- clk  input  1  clock; all state changes occur on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- en  input  1  count enable; 0 freezes the state.
- clr  input  1  synchronous clear to state 0; overrides en and in.
- in  input  1  serial event input, sampled on the rising edge of clk.
- out  output  1  Moore output; equals (state == TARGET), decoded from the state register only.
- count  output  WIDTH  current state register.
- hit  output  1  registered one-cycle pulse, high on the first cycle of each entry into TARGET.

## Operation
- Single state register `state[WIDTH-1:0]`. The value never exceeds TARGET, so values above TARGET are unreachable.
- Next-state priority at each rising edge (rst low):
  1. clr=1 → 0.
  2. en=0 → hold.
  3. state < TARGET, in=1 → state+1.
  4. state < TARGET, in=0 → hold (MODE=0) or 0 (MODE=1).
  5. state == TARGET, in=0 → hold (both modes).
  6. state == TARGET, in=1 → 0 (WRAP=1) or hold (WRAP=0).
- out depends on state only, never on in, en or clr.
- hit register loads 1 when the next state is TARGET and the current state is not TARGET; otherwise it loads 0.
  - Consequence: hit and out rise on the same edge, and hit falls one cycle later.
  - Holding in TARGET does not re-pulse hit.
  - Wrapping out of TARGET and later re-entering produces a new pulse.
- Corner case TARGET=1, WRAP=1, in held at 1: state alternates 0,1,0,1; out toggles; hit pulses on every entry.
- clr while already at 0: no effect, and hit stays 0.
- clr issued on the same edge that would enter TARGET: clr wins; state becomes 0 and hit stays 0.

## Timing
- Reset (asynchronous) immediately forces state=0, out=0, count=0, hit=0, without waiting for a clock edge.
- Release of rst is synchronous to clk: the first state update occurs on the first rising edge after rst falls.
- Reset asserted mid-count discards the count; no partial state survives.
- Latency: out and hit go high 0 cycles after the edge that samples the TARGET-th qualifying in=1, i.e. they are visible for the whole following cycle.
- count, out and hit are glitch-free register outputs or direct decodes of registers; there is no combinational path from any input to any output.

## Test plan
- **Reset:** assert rst asynchronously mid-cycle with state=2 → out=0, count=0, hit=0 before the next clk edge. Deassert rst → first counting edge is the next rising edge.
- **Default config (WIDTH=4, TARGET=3, MODE=0, WRAP=1):** in = 1,0,1,1,0,1 on successive edges → count = 1,1,2,3,3,0.
  - out is high for the two cycles at state 3.
  - hit is high exactly one cycle, after the 4th edge.
- **Consecutive mode (MODE=1, TARGET=3):** in = 1,1,0,1,1,1,0 → count = 1,2,0,1,2,3,3.
  - out stays high after the 6th edge.
  - hit is high exactly once.
- **Saturation (WRAP=0, TARGET=5, WIDTH=3):** seven in=1 edges → count = 1..5, then 5,5.
  - hit pulses once.
  - clr=1 then returns count to 0 and out to 0.
- **Priority:**
  - State 2, TARGET=3, in=1, clr=1 on the same edge → count=0, hit=0.
  - State 2, en=0, in=1 → count stays 2.
- **Wide config (WIDTH=8, TARGET=200, MODE=0, WRAP=1):** 200 in=1 edges → out rises after the 200th edge. The 201st in=1 edge → count=0.

Source files
------------

// File: rtl/moore_seq_counter.sv
// Moore threshold counter: counts qualifying in=1 cycles up to TARGET,
// raises out while at TARGET and pulses hit on each entry into TARGET.
// Ports: clk, rst (async, active-high), en, clr (sync), in -> out, count, hit.
module moore_seq_counter #(
  parameter int WIDTH  = 4,
  parameter int TARGET = 3,
  parameter int MODE   = 0,
  parameter int WRAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             in,
  output logic             out,
  output logic [WIDTH-1:0] count,
  output logic             hit
);

  if (TARGET < 1 || TARGET > (2**WIDTH) - 1) begin : g_bad_target
    $error("moore_seq_counter: TARGET out of range");
  end

  localparam logic [WIDTH-1:0] TGT = WIDTH'(TARGET);

  logic [WIDTH-1:0] state_q, state_d;
  logic             hit_q, hit_d;

  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    if (clr) begin
      state_d = '0;
    end else if (en) begin
      if (state_q < TGT) begin
        if (in) begin
          state_d = state_q + 1'b1;
        end else if (MODE == 1) begin
          state_d = '0;
        end
      end else if (in && (WRAP == 1)) begin
        state_d = '0;
      end
    end
    // Pulse only on the edge that moves into TARGET from elsewhere.
    hit_d = (state_d == TGT) && (state_q != TGT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
    end
  end

  assign out   = (state_q == TGT);
  assign count = state_q;
  assign hit   = hit_q;

endmodule

// File: tb/tb_moore_seq_counter.sv
// Self-checking bench: four configurations share one stimulus stream and
// are compared against an integer reference model every cycle.
module tb_moore_seq_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic clr = 1'b0;
  logic in  = 1'b0;

  logic       out0, out1, out2, out3;
  logic       hit0, hit1, hit2, hit3;
  logic [3:0] cnt0, cnt1;
  logic [2:0] cnt2;
  logic [7:0] cnt3;

  int n_vec = 0;
  int n_bad = 0;

  int tgt  [4] = '{3, 3, 5, 200};
  int mode [4] = '{0, 1, 0, 0};
  int wrap [4] = '{1, 1, 0, 1};
  int m_cnt[4];
  int m_hit[4];

  always #5 clk = ~clk;

  moore_seq_counter u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in(in),
    .out(out0), .count(cnt0), .hit(hit0)
  );

  moore_seq_counter #(.WIDTH(4), .TARGET(3), .MODE(1), .WRAP(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in(in),
    .out(out1), .count(cnt1), .hit(hit1)
  );

  moore_seq_counter #(.WIDTH(3), .TARGET(5), .MODE(0), .WRAP(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in(in),
    .out(out2), .count(cnt2), .hit(hit2)
  );

  moore_seq_counter #(.WIDTH(8), .TARGET(200), .MODE(0), .WRAP(1)) u3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in(in),
    .out(out3), .count(cnt3), .hit(hit3)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int obs_cnt(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  function automatic int obs_out(input int k);
    case (k)
      0:       return int'(out0);
      1:       return int'(out1);
      2:       return int'(out2);
      default: return int'(out3);
    endcase
  endfunction

  function automatic int obs_hit(input int k);
    case (k)
      0:       return int'(hit0);
      1:       return int'(hit1);
      2:       return int'(hit2);
      default: return int'(hit3);
    endcase
  endfunction

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d.count", k), obs_cnt(k), m_cnt[k]);
      chk($sformatf("u%0d.out", k), obs_out(k),
          (m_cnt[k] == tgt[k]) ? 1 : 0);
      chk($sformatf("u%0d.hit", k), obs_hit(k), m_hit[k]);
    end
  endtask

  // Reference: count qualifying ones up to the threshold.
  task automatic model(input logic e, input logic c, input logic i);
    for (int k = 0; k < 4; k++) begin
      int cur = m_cnt[k];
      int nxt = cur;
      if (c) nxt = 0;
      else if (!e) nxt = cur;
      else if (cur < tgt[k]) nxt = i ? cur + 1 : (mode[k] == 1 ? 0 : cur);
      else if (i && wrap[k] == 1) nxt = 0;
      m_hit[k] = (nxt == tgt[k] && cur != tgt[k]) ? 1 : 0;
      m_cnt[k] = nxt;
    end
  endtask

  task automatic step(input logic e, input logic c, input logic i);
    @(negedge clk);
    en = e; clr = c; in = i;
    @(posedge clk);
    model(e, c, i);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0;
      m_hit[k] = 0;
    end
  endtask

  // Assert rst between edges and check it takes effect immediately.
  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; clr = 1'b0; in = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic seq_a [6] = '{1, 0, 1, 1, 0, 1};
  int   exp_a [6] = '{1, 1, 2, 3, 3, 0};
  int   hit_a [6] = '{0, 0, 0, 1, 0, 0};
  logic seq_b [7] = '{1, 1, 0, 1, 1, 1, 0};
  int   exp_b [7] = '{1, 2, 0, 1, 2, 3, 3};
  int   exp_c [7] = '{1, 2, 3, 4, 5, 5, 5};

  initial begin
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    for (int j = 0; j < 6; j++) begin
      step(1'b1, 1'b0, seq_a[j]);
      chk("plan.default.count", int'(cnt0), exp_a[j]);
      chk("plan.default.hit", int'(hit0), hit_a[j]);
    end

    do_reset();
    for (int j = 0; j < 7; j++) begin
      step(1'b1, 1'b0, seq_b[j]);
      chk("plan.consec.count", int'(cnt1), exp_b[j]);
    end

    do_reset();
    for (int j = 0; j < 7; j++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("plan.sat.count", int'(cnt2), exp_c[j]);
    end
    step(1'b1, 1'b1, 1'b1);
    chk("plan.sat.clr", int'(cnt2), 0);
    chk("plan.sat.out", int'(out2), 0);

    do_reset();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("plan.en0.hold", int'(cnt0), 2);
    step(1'b1, 1'b1, 1'b1);
    chk("plan.clr_wins.count", int'(cnt0), 0);
    chk("plan.clr_wins.hit", int'(hit0), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("plan.clr_at0.hit", int'(hit0), 0);

    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    do_reset();
    chk("plan.midreset.count", int'(cnt0), 0);

    for (int j = 0; j < 200; j++) step(1'b1, 1'b0, 1'b1);
    chk("plan.wide.out", int'(out3), 1);
    chk("plan.wide.hit", int'(hit3), 1);
    step(1'b1, 1'b0, 1'b1);
    chk("plan.wide.wrap", int'(cnt3), 0);

    do_reset();
    for (int j = 0; j < 3000; j++) begin
      step($urandom_range(0, 9) != 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
